// File: rtl/imem_load_sequencer.sv
// imem_load_sequencer
// Loads a host-supplied program into instruction memory starting at word 0,
// holds the CPU in reset while loading, then releases it to run. A reload
// request while running puts the CPU back into reset and starts over at
// address 0.
module imem_load_sequencer #(
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 32,
  parameter int RESET_HOLD = 2
) (
  input  logic              clk,
  input  logic              Reset_n,
  input  logic              load_req,
  input  logic              instr_valid,
  input  logic [DATA_W-1:0] instr_in,
  output logic              instr_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              cpu_reset,
  output logic              cpu_run,
  output logic              busy,
  output logic [ADDR_W:0]   instr_count,
  output logic              overflow
);

  localparam int DEPTH  = 2 ** ADDR_W;
  localparam int HOLD_W = (RESET_HOLD < 2) ? 1 : $clog2(RESET_HOLD);

  localparam logic [ADDR_W:0]   FULL_COUNT = (ADDR_W + 1)'(DEPTH);
  localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(RESET_HOLD - 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_FLUSH = 3'd2;
  localparam logic [2:0] ST_HOLD  = 3'd3;
  localparam logic [2:0] ST_RUN   = 3'd4;

  logic [2:0]        state_reg;
  logic [2:0]        state_next;
  logic [ADDR_W:0]   count_reg;
  logic              overflow_reg;
  logic [HOLD_W-1:0] hold_cnt_reg;
  logic              we_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] wdata_reg;

  logic full;
  logic in_load;
  logic accept;
  logic enter_load;

  // Once count reaches DEPTH nothing more is accepted; there is no wrap.
  assign full       = (count_reg == FULL_COUNT);
  assign in_load    = (state_reg == ST_LOAD);
  assign accept     = in_load && instr_valid && !full;
  assign enter_load = (state_next == ST_LOAD) && !in_load;

  // Next-state decode for the load/run lifecycle.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (load_req) state_next = ST_LOAD;
      ST_LOAD:  if (!load_req) state_next = ST_FLUSH;
      ST_FLUSH: state_next = ST_HOLD;
      ST_HOLD:  if (hold_cnt_reg == HOLD_LAST) state_next = ST_RUN;
      ST_RUN:   if (load_req) state_next = ST_LOAD;
      default:  state_next = ST_IDLE;
    endcase
  end

  // State register; reset drops straight to IDLE, abandoning any load.
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Word counter and sticky overflow, both cleared on every entry to LOAD.
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else if (enter_load) begin
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (accept) begin
        count_reg <= count_reg + (ADDR_W + 1)'(1);
      end
      if (in_load && instr_valid && full) begin
        overflow_reg <= 1'b1;
      end
    end
  end

  // Counts HOLD cycles so cpu_reset stays asserted for exactly RESET_HOLD of them.
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      hold_cnt_reg <= '0;
    end else if ((state_reg == ST_HOLD) && (state_next == ST_HOLD)) begin
      hold_cnt_reg <= hold_cnt_reg + HOLD_W'(1);
    end else begin
      hold_cnt_reg <= '0;
    end
  end

  // Registered write port: an accepted beat is written on the following cycle.
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
    end else begin
      we_reg <= accept;
      if (accept) begin
        addr_reg  <= count_reg[ADDR_W-1:0];
        wdata_reg <= instr_in;
      end
    end
  end

  assign instr_ready = in_load && !full;
  assign imem_we     = we_reg;
  assign imem_addr   = addr_reg;
  assign imem_wdata  = wdata_reg;
  assign cpu_reset   = (state_reg != ST_RUN);
  assign cpu_run     = (state_reg == ST_RUN);
  assign busy        = in_load || (state_reg == ST_FLUSH) || (state_reg == ST_HOLD);
  assign instr_count = count_reg;
  assign overflow    = overflow_reg;

endmodule

// File: tb/tb_imem_load_sequencer.sv
// Directed bench for imem_load_sequencer: a 32-word instance covers normal
// loads, reloads and reset abort; a 4-word instance covers the full/overflow
// case. Expected writes are queued as beats are driven and popped by monitors.
module tb_imem_load_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // instance A: ADDR_W = 5
  logic        a_rst_n, a_load_req, a_valid;
  logic [31:0] a_in;
  logic        a_ready, a_we, a_cpu_reset, a_cpu_run, a_busy, a_ovf;
  logic [4:0]  a_addr;
  logic [31:0] a_wdata;
  logic [5:0]  a_count;

  // instance B: ADDR_W = 2
  logic        b_rst_n, b_load_req, b_valid;
  logic [31:0] b_in;
  logic        b_ready, b_we, b_cpu_reset, b_cpu_run, b_busy, b_ovf;
  logic [1:0]  b_addr;
  logic [31:0] b_wdata;
  logic [2:0]  b_count;

  logic [63:0] a_q[$];
  logic [63:0] b_q[$];

  logic [31:0] prog [13] = '{
    32'h20010008, 32'h20020001, 32'h00221820, 32'h00222022, 32'h00412824,
    32'h00413025, 32'h0041382a, 32'h8c080004, 32'hac080008, 32'h10220002,
    32'h200b0005, 32'h200c0003, 32'h016c682a
  };
  int gap [6] = '{1, 0, 1, 1, 0, 1};

  imem_load_sequencer #(.ADDR_W(5), .DATA_W(32), .RESET_HOLD(2)) dut_a (
    .clk(clk), .Reset_n(a_rst_n), .load_req(a_load_req), .instr_valid(a_valid),
    .instr_in(a_in), .instr_ready(a_ready), .imem_we(a_we), .imem_addr(a_addr),
    .imem_wdata(a_wdata), .cpu_reset(a_cpu_reset), .cpu_run(a_cpu_run),
    .busy(a_busy), .instr_count(a_count), .overflow(a_ovf)
  );

  imem_load_sequencer #(.ADDR_W(2), .DATA_W(32), .RESET_HOLD(2)) dut_b (
    .clk(clk), .Reset_n(b_rst_n), .load_req(b_load_req), .instr_valid(b_valid),
    .instr_in(b_in), .instr_ready(b_ready), .imem_we(b_we), .imem_addr(b_addr),
    .imem_wdata(b_wdata), .cpu_reset(b_cpu_reset), .cpu_run(b_cpu_run),
    .busy(b_busy), .instr_count(b_count), .overflow(b_ovf)
  );

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_cmp++;
    assert (observed === expected) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Write monitors: every imem write must match the head of the scoreboard.
  always @(negedge clk) begin
    if (a_we) begin
      if (a_q.size() == 0) begin
        check("a_unexpected_we", 64'(a_we), 64'd0);
      end else begin
        logic [63:0] exp_w;
        exp_w = a_q.pop_front();
        check("a_write", {32'(a_addr), a_wdata}, exp_w);
        $display("A write addr=%0d data=%08h", a_addr, a_wdata);
      end
    end
  end

  always @(negedge clk) begin
    if (b_we) begin
      if (b_q.size() == 0) begin
        check("b_unexpected_we", 64'(b_we), 64'd0);
      end else begin
        logic [63:0] exp_w;
        exp_w = b_q.pop_front();
        check("b_write", {32'(b_addr), b_wdata}, exp_w);
        $display("B write addr=%0d data=%08h", b_addr, b_wdata);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    a_rst_n = 1'b0; a_load_req = 1'b0; a_valid = 1'b0; a_in = '0;
    b_rst_n = 1'b0; b_load_req = 1'b0; b_valid = 1'b0; b_in = '0;
    #1;
    // reset asserted asynchronously
    check("rst_async_cpu_reset", 64'(a_cpu_reset), 64'd1);
    check("rst_async_we", 64'(a_we), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    a_rst_n = 1'b1; b_rst_n = 1'b1;
    tick();
    check("rst_cpu_reset", 64'(a_cpu_reset), 64'd1);
    check("rst_cpu_run", 64'(a_cpu_run), 64'd0);
    check("rst_we", 64'(a_we), 64'd0);
    check("rst_busy", 64'(a_busy), 64'd0);
    check("rst_count", 64'(a_count), 64'd0);
    check("rst_ready", 64'(a_ready), 64'd0);
    check("rst_overflow", 64'(a_ovf), 64'd0);
    check("rst_b_cpu_reset", 64'(b_cpu_reset), 64'd1);

    // 13-beat program, load_req dropped with the last beat
    a_load_req = 1'b1;
    tick();
    check("load_busy", 64'(a_busy), 64'd1);
    check("load_ready", 64'(a_ready), 64'd1);
    for (int i = 0; i < 13; i++) begin
      a_valid = 1'b1;
      a_in = prog[i];
      a_q.push_back({32'(i), prog[i]});
      if (i == 12) a_load_req = 1'b0;
      tick();
    end
    a_valid = 1'b0; a_in = '0;
    check("flush_count", 64'(a_count), 64'd13);
    check("flush_busy", 64'(a_busy), 64'd1);
    check("flush_cpu_reset", 64'(a_cpu_reset), 64'd1);
    check("flush_ready", 64'(a_ready), 64'd0);
    for (int h = 0; h < 2; h++) begin
      tick();
      check("hold_cpu_reset", 64'(a_cpu_reset), 64'd1);
      check("hold_cpu_run", 64'(a_cpu_run), 64'd0);
    end
    tick();
    check("run_cpu_reset", 64'(a_cpu_reset), 64'd0);
    check("run_cpu_run", 64'(a_cpu_run), 64'd1);
    check("run_busy", 64'(a_busy), 64'd0);
    check("run_count", 64'(a_count), 64'd13);

    // valid outside LOAD is ignored
    a_valid = 1'b1; a_in = 32'hdeadbeef;
    repeat (3) tick();
    a_valid = 1'b0;
    check("ignored_overflow", 64'(a_ovf), 64'd0);
    check("ignored_count", 64'(a_count), 64'd13);

    // reload from RUN, gapped beats, load_req dropped on last beat
    a_load_req = 1'b1;
    check("pre_reload_cpu_reset", 64'(a_cpu_reset), 64'd0);
    tick();
    check("reload_cpu_reset", 64'(a_cpu_reset), 64'd1);
    check("reload_count", 64'(a_count), 64'd0);
    check("reload_cpu_run", 64'(a_cpu_run), 64'd0);
    n = 0;
    for (int j = 0; j < 6; j++) begin
      a_valid = (gap[j] != 0);
      a_in = 32'h10000000 + 32'(j);
      if (gap[j] != 0) begin
        a_q.push_back({32'(n), 32'h10000000 + 32'(j)});
        n++;
      end
      if (j == 5) a_load_req = 1'b0;
      tick();
    end
    a_valid = 1'b0;
    check("gap_count", 64'(a_count), 64'd4);
    check("gap_flush_busy", 64'(a_busy), 64'd1);
    tick();
    check("gap_hold1_cpu_reset", 64'(a_cpu_reset), 64'd1);
    tick();
    check("gap_hold2_cpu_reset", 64'(a_cpu_reset), 64'd1);
    tick();
    check("gap_run", 64'(a_cpu_run), 64'd1);

    // reset mid-LOAD after 3 beats
    a_load_req = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      a_valid = 1'b1;
      a_in = 32'h30000000 + 32'(i);
      a_q.push_back({32'(i), 32'h30000000 + 32'(i)});
      tick();
    end
    a_valid = 1'b0;
    tick();
    a_rst_n = 1'b0;
    a_valid = 1'b1; a_in = 32'h3badbad0;
    #1;
    check("abort_we", 64'(a_we), 64'd0);
    check("abort_cpu_reset", 64'(a_cpu_reset), 64'd1);
    check("abort_busy", 64'(a_busy), 64'd0);
    check("abort_count", 64'(a_count), 64'd0);
    repeat (2) tick();
    check("abort_pending", 64'(a_q.size()), 64'd0);
    a_rst_n = 1'b1; a_valid = 1'b0; a_load_req = 1'b0;
    tick();

    // zero-beat load
    a_load_req = 1'b1;
    tick();
    check("empty_busy", 64'(a_busy), 64'd1);
    a_load_req = 1'b0;
    tick();
    check("empty_flush_count", 64'(a_count), 64'd0);
    repeat (2) tick();
    check("empty_hold_cpu_reset", 64'(a_cpu_reset), 64'd1);
    tick();
    check("empty_run", 64'(a_cpu_run), 64'd1);
    check("empty_run_count", 64'(a_count), 64'd0);

    // 4-word instance: fifth beat dropped, overflow sticky until reload
    b_load_req = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      check("b_ready", 64'(b_ready), (i < 4) ? 64'd1 : 64'd0);
      b_valid = 1'b1;
      b_in = 32'hb0000000 + 32'(i);
      if (i < 4) b_q.push_back({32'(i), 32'hb0000000 + 32'(i)});
      tick();
    end
    b_valid = 1'b0;
    check("b_overflow", 64'(b_ovf), 64'd1);
    check("b_count", 64'(b_count), 64'd4);
    check("b_ready_full", 64'(b_ready), 64'd0);
    b_load_req = 1'b0;
    repeat (4) tick();
    check("b_run", 64'(b_cpu_run), 64'd1);
    check("b_run_overflow", 64'(b_ovf), 64'd1);
    b_load_req = 1'b1;
    tick();
    check("b_reload_overflow", 64'(b_ovf), 64'd0);
    check("b_reload_count", 64'(b_count), 64'd0);
    check("b_reload_ready", 64'(b_ready), 64'd1);
    b_load_req = 1'b0;
    repeat (4) tick();
    check("b_rerun", 64'(b_cpu_run), 64'd1);

    repeat (2) tick();
    check("a_pending_end", 64'(a_q.size()), 64'd0);
    check("b_pending_end", 64'(b_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
